adc_decimator: RTL and testbench

ADC_DECIMATOR -- requirements
Module: adc_decimator

---
 rtl/adc_decimator_pkg.sv | 43 ++++
 rtl/adc_dec_channel.sv | 98 +++++++++
 rtl/adc_decimator.sv | 190 +++++++++++++++++++
 tb/tb_adc_decimator.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_decimator_pkg.sv
// -----------------------------------------------------------------------------
// adc_decimator_pkg
// Shared definitions for the ADC decimator and the ADC controller wrapper.
// It holds:
//   - the IAGC status codes, all 13 of them,
//   - the default largest decimation exponent,
//   - the FSM state type,
//   - a helper that returns the last sample index of a group of 2^k samples.
// -----------------------------------------------------------------------------
package adc_decimator_pkg;

   localparam int unsigned DEC_LOG2_MAX_DEF = 8;
   localparam int unsigned CNT_W            = 8;

   // IAGC status codes
   localparam int unsigned IAGC_RESET      = 0;
   localparam int unsigned IAGC_WAIT_INIT  = 1;
   localparam int unsigned IAGC_CFG_ADC    = 2;
   localparam int unsigned IAGC_SAMPLE     = 3;
   localparam int unsigned IAGC_COMPUTE    = 4;
   localparam int unsigned IAGC_CHECK_LOW  = 5;
   localparam int unsigned IAGC_CHECK_HIGH = 6;
   localparam int unsigned IAGC_INC_GAIN   = 7;
   localparam int unsigned IAGC_DEC_GAIN   = 8;
   localparam int unsigned IAGC_APPLY_GAIN = 9;
   localparam int unsigned IAGC_SETTLE     = 10;
   localparam int unsigned IAGC_SET_DEC    = 11;
   localparam int unsigned IAGC_ERROR      = 12;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } dec_state_e;

   // Index of the last sample in a group of 2^k samples.
   // The index is taken modulo 256, so k=8 yields 255.
   function automatic logic [CNT_W-1:0] last_index(input logic [3:0] k_i);
      logic [CNT_W:0] n_v;
      n_v = 9'd1 << k_i;
      return 8'(n_v - 9'd1);
   endfunction

endpackage

// File: rtl/adc_dec_channel.sv
// -----------------------------------------------------------------------------
// adc_dec_channel
// Computes the result for one channel over a group of samples.
//
// Build-time option (macro ADC_DECIMATOR_AVERAGE_EN):
//   defined   : the result is the boxcar mean. The N samples are summed and the
//               sum is arithmetic-shifted right by k.
//   undefined : the result is the first sample of each group. Only that sample
//               is stored; no accumulator is built.
//
// Ports:
//   clk_i     clock, rising edge
//   rst_ni    asynchronous reset, active low
//   accept_i  a sample is taken this cycle; low clears any partial group
//   first_i   the sample is the first of its group
//   last_i    the sample is the last of its group
//   shift_i   decimation exponent k
//   sample_i  signed sample
//   result_o  group result, valid when accept_i & last_i (combinational)
// -----------------------------------------------------------------------------
module adc_dec_channel
   import adc_decimator_pkg::*;
#(
   parameter int DATA_SIZE    = 14,
   parameter int DEC_LOG2_MAX = DEC_LOG2_MAX_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 accept_i,
   input  logic                 first_i,
   input  logic                 last_i,
   input  logic [3:0]           shift_i,
   input  logic [DATA_SIZE-1:0] sample_i,
   output logic [DATA_SIZE-1:0] result_o
);

   localparam int ACC_SIZE = DATA_SIZE + DEC_LOG2_MAX;

`ifdef ADC_DECIMATOR_AVERAGE_EN
   logic signed [ACC_SIZE-1:0] acc_q, acc_d, sum_s;

   // Running sum. The first sample of a group restarts the sum, so a stale
   // accumulator value never leaks into a new group.
   always_comb begin
      if (first_i) begin
         sum_s = ACC_SIZE'($signed(sample_i));
      end else begin
         sum_s = acc_q + ACC_SIZE'($signed(sample_i));
      end
      result_o = DATA_SIZE'(sum_s >>> shift_i);
      if (!accept_i || last_i) begin
         acc_d = '0;
      end else begin
         acc_d = sum_s;
      end
   end

   // Accumulator register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end
`else
   logic [DATA_SIZE-1:0] first_q, first_d;
   logic                 unused_cfg_s;

   assign unused_cfg_s = ^{last_i, shift_i, 8'(ACC_SIZE)};

   // Keep the first sample of the group. With N=1 the live sample is the result.
   always_comb begin
      if (!accept_i) begin
         first_d = '0;
      end else if (first_i) begin
         first_d = sample_i;
      end else begin
         first_d = first_q;
      end
      if (first_i) begin
         result_o = sample_i;
      end else begin
         result_o = first_q;
      end
   end

   // First-sample register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         first_q <= '0;
      end else begin
         first_q <= first_d;
      end
   end
`endif

endmodule

// File: rtl/adc_decimator.sv
// -----------------------------------------------------------------------------
// adc_decimator
// Decimates two ADC channels by N = 2^k. The block contains:
//   - an IDLE/ACC FSM driven by the IAGC status,
//   - an 8-bit sample counter,
//   - a valid/ready output holding register with a sticky overrun flag.
//
// Build-time option: macro ADC_DECIMATOR_AVERAGE_EN.
//   defined   : boxcar mean of each group
//   undefined : first sample of each group
//
// Ports:
//   i_sys_clock      clock, rising edge
//   i_reset_n        asynchronous reset, active low
//   i_iagc_status    IAGC state (RESET clears, SAMPLE runs, SET_DEC loads k)
//   i_adc_init_done  ADC controller configured
//   i_adc_data_ch1/2 one signed sample per clock per channel
//   i_dec_log2       requested decimation exponent
//   i_ready          downstream accepts the output this cycle
//   o_data_ch1/2     decimated samples
//   o_valid          output pair valid
//   o_overrun        sticky: a result was dropped
//   o_busy           FSM is in ACC
// -----------------------------------------------------------------------------
module adc_decimator
   import adc_decimator_pkg::*;
#(
   parameter int DATA_SIZE        = 14,
   parameter int IAGC_STATUS_SIZE = 4,
   parameter int DEC_LOG2_MAX     = DEC_LOG2_MAX_DEF
) (
   input  logic                        i_sys_clock,
   input  logic                        i_reset_n,
   input  logic [IAGC_STATUS_SIZE-1:0] i_iagc_status,
   input  logic                        i_adc_init_done,
   input  logic [DATA_SIZE-1:0]        i_adc_data_ch1,
   input  logic [DATA_SIZE-1:0]        i_adc_data_ch2,
   input  logic [3:0]                  i_dec_log2,
   input  logic                        i_ready,
   output logic [DATA_SIZE-1:0]        o_data_ch1,
   output logic [DATA_SIZE-1:0]        o_data_ch2,
   output logic                        o_valid,
   output logic                        o_overrun,
   output logic                        o_busy
);

   localparam logic [IAGC_STATUS_SIZE-1:0] ST_RESET   = IAGC_STATUS_SIZE'(IAGC_RESET);
   localparam logic [IAGC_STATUS_SIZE-1:0] ST_SAMPLE  = IAGC_STATUS_SIZE'(IAGC_SAMPLE);
   localparam logic [IAGC_STATUS_SIZE-1:0] ST_SET_DEC = IAGC_STATUS_SIZE'(IAGC_SET_DEC);
   localparam logic [3:0]                  K_MAX      = 4'(DEC_LOG2_MAX);

   dec_state_e           state_q, state_d;
   logic [3:0]           k_q, k_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [DATA_SIZE-1:0] data1_q, data1_d, data2_q, data2_d;
   logic                 valid_q, valid_d, overrun_q, overrun_d, busy_q, busy_d;
   logic                 run_s, clear_s, first_s, last_s, load_s;
   logic [DATA_SIZE-1:0] res1_s, res2_s;

   // Sampling conditions. A sample is taken whenever the FSM is, or is about
   // to be, in ACC. This covers the IDLE->ACC transition cycle.
   always_comb begin
      run_s   = (i_iagc_status == ST_SAMPLE) && i_adc_init_done;
      clear_s = (i_iagc_status == ST_RESET);
      first_s = (cnt_q == 8'd0);
      last_s  = (cnt_q == last_index(k_q));
      load_s  = run_s && last_s;
   end

   adc_dec_channel #(
      .DATA_SIZE    (DATA_SIZE),
      .DEC_LOG2_MAX (DEC_LOG2_MAX)
   ) u_ch1 (
      .clk_i    (i_sys_clock),
      .rst_ni   (i_reset_n),
      .accept_i (run_s),
      .first_i  (first_s),
      .last_i   (last_s),
      .shift_i  (k_q),
      .sample_i (i_adc_data_ch1),
      .result_o (res1_s)
   );

   adc_dec_channel #(
      .DATA_SIZE    (DATA_SIZE),
      .DEC_LOG2_MAX (DEC_LOG2_MAX)
   ) u_ch2 (
      .clk_i    (i_sys_clock),
      .rst_ni   (i_reset_n),
      .accept_i (run_s),
      .first_i  (first_s),
      .last_i   (last_s),
      .shift_i  (k_q),
      .sample_i (i_adc_data_ch2),
      .result_o (res2_s)
   );

   // Next-state logic: FSM, k, counter and output handshake
   always_comb begin
      case (state_q)
         ST_IDLE: begin
            if (run_s) begin
               state_d = ST_ACC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACC: begin
            if (run_s) begin
               state_d = ST_ACC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d == ST_ACC);

      if ((state_q == ST_IDLE) && (i_iagc_status == ST_SET_DEC)) begin
         k_d = (i_dec_log2 > K_MAX) ? K_MAX : i_dec_log2;
      end else begin
         k_d = k_q;
      end

      // Leaving SAMPLE discards the partial group.
      if (!run_s) begin
         cnt_d = '0;
      end else if (last_s) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      data1_d   = data1_q;
      data2_d   = data2_q;
      valid_d   = valid_q;
      overrun_d = overrun_q;
      if (clear_s) begin
         data1_d   = '0;
         data2_d   = '0;
         valid_d   = 1'b0;
         overrun_d = 1'b0;
      end else if (load_s) begin
         // A held result still waiting for ready wins; the new one is dropped.
         if (!valid_q || i_ready) begin
            data1_d = res1_s;
            data2_d = res2_s;
            valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
   end

   // State and output registers
   always_ff @(posedge i_sys_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         k_q       <= 4'd0;
         cnt_q     <= '0;
         data1_q   <= '0;
         data2_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         k_q       <= k_d;
         cnt_q     <= cnt_d;
         data1_q   <= data1_d;
         data2_q   <= data2_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         busy_q    <= busy_d;
      end
   end

   assign o_data_ch1 = data1_q;
   assign o_data_ch2 = data2_q;
   assign o_valid    = valid_q;
   assign o_overrun  = overrun_q;
   assign o_busy     = busy_q;

endmodule

// File: tb/tb_adc_decimator.sv
// Self-checking bench for adc_decimator: directed scenarios plus random traffic,
// compared against a group/queue-level reference model.
module tb_adc_decimator;

   localparam int DW = 14;

   logic          clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic [3:0]    i_iagc_status = 4'd0;
   logic          i_adc_init_done = 1'b0;
   logic [DW-1:0] i_adc_data_ch1 = '0;
   logic [DW-1:0] i_adc_data_ch2 = '0;
   logic [3:0]    i_dec_log2 = 4'd0;
   logic          i_ready = 1'b0;
   logic [DW-1:0] o_data_ch1, o_data_ch2;
   logic          o_valid, o_overrun, o_busy;
   logic [30:0]   dut_v;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit m_valid, m_ovr, m_busy;
   int m_d1, m_d2, m_k;
   int g1[$];
   int g2[$];

   always #5 clk = ~clk;

   adc_decimator dut (
      .i_sys_clock     (clk),
      .i_reset_n       (i_reset_n),
      .i_iagc_status   (i_iagc_status),
      .i_adc_init_done (i_adc_init_done),
      .i_adc_data_ch1  (i_adc_data_ch1),
      .i_adc_data_ch2  (i_adc_data_ch2),
      .i_dec_log2      (i_dec_log2),
      .i_ready         (i_ready),
      .o_data_ch1      (o_data_ch1),
      .o_data_ch2      (o_data_ch2),
      .o_valid         (o_valid),
      .o_overrun       (o_overrun),
      .o_busy          (o_busy)
   );

   assign dut_v = {o_valid, o_overrun, o_busy, o_data_ch1, o_data_ch2};

   function automatic int floor_div(input longint s, input int n);
      longint q;
      q = s / n;
      if ((s % n) != 0 && s < 0) q = q - 1;
      return int'(q);
   endfunction

   function automatic int group_result(input int q[$]);
`ifdef ADC_DECIMATOR_AVERAGE_EN
      longint s;
      s = 0;
      foreach (q[i]) s += q[i];
      return floor_div(s, q.size());
`else
      return q[0];
`endif
   endfunction

   function automatic logic [30:0] exp_v();
      return {m_valid, m_ovr, m_busy, 14'(m_d1), 14'(m_d2)};
   endfunction

   function automatic void model_reset();
      m_valid = 0; m_ovr = 0; m_busy = 0; m_d1 = 0; m_d2 = 0; m_k = 0;
      g1.delete(); g2.delete();
   endfunction

   function automatic void model_clock(input int st, input bit init, input int dec,
                                       input bit rdy, input int d1, input int d2);
      bit run, ld;
      int r1, r2;
      run = (st == 3) && init;
      ld = 0; r1 = 0; r2 = 0;
      if (st == 0) begin
         m_valid = 0; m_ovr = 0; m_busy = 0; m_d1 = 0; m_d2 = 0;
         g1.delete(); g2.delete();
         return;
      end
      if (!m_busy && st == 11) m_k = (dec > 8) ? 8 : dec;
      if (run) begin
         g1.push_back(d1); g2.push_back(d2);
         if (g1.size() == (1 << m_k)) begin
            r1 = group_result(g1); r2 = group_result(g2); ld = 1;
            g1.delete(); g2.delete();
         end
      end else begin
         g1.delete(); g2.delete();
      end
      if (ld) begin
         if (!m_valid || rdy) begin
            m_valid = 1; m_d1 = r1; m_d2 = r2;
         end else begin
            m_ovr = 1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 0;
      end
      m_busy = run;
   endfunction

   // One clock: drive inputs, let the edge happen, advance the model, settle.
   task automatic step(input int st, input bit init, input int dec, input bit rdy,
                       input int d1, input int d2);
      i_iagc_status   = 4'(st);
      i_adc_init_done = init;
      i_dec_log2      = 4'(dec);
      i_ready         = rdy;
      i_adc_data_ch1  = 14'(d1);
      i_adc_data_ch2  = 14'(d2);
      @(posedge clk);
      model_clock(st, init, dec, rdy, d1, d2);
      #1;
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(0, 16383)) - 8192;
   endfunction

   task automatic test_reset();
      i_reset_n = 1'b0;
      #12;
      n_tests++;
      if (dut_v !== 31'd0) begin
         n_fail++;
         $display("FAIL reset_state: got %h want %h", dut_v, 31'd0);
      end
      model_reset();
      i_reset_n = 1'b1;
      step(1, 0, 0, 1, 0, 0);
      n_tests++;
      if (dut_v !== exp_v()) begin
         n_fail++;
         $display("FAIL reset_idle: got %h want %h", dut_v, exp_v());
      end
   endtask

   task automatic test_ramp_k0();
      for (int i = 0; i < 10; i++) begin
         step(3, 1, 0, 1, i, rnd_sample());
         n_tests++;
         if (o_valid !== 1'b1 || o_data_ch1 !== 14'(i)) begin
            n_fail++;
            $display("FAIL ramp_k0 %0d: got v=%b d=%0d want v=1 d=%0d", i, o_valid, o_data_ch1, i);
         end
         n_tests++;
         if (dut_v !== exp_v()) begin
            n_fail++;
            $display("FAIL ramp_model %0d: got %h want %h", i, dut_v, exp_v());
         end
      end
      step(1, 1, 0, 1, 0, 0);
      step(1, 1, 0, 1, 0, 0);
   endtask

   task automatic test_fixed_k2();
      int a1[4];
      int a2[4];
      int e1, e2, pulses;
`ifdef ADC_DECIMATOR_AVERAGE_EN
      a1 = '{4, 8, 12, 16}; a2 = '{-1, -1, -1, -2}; e1 = 10; e2 = -2;
`else
      a1 = '{5, 6, 7, 8};   a2 = '{1, 2, 3, 4};     e1 = 5;  e2 = 1;
`endif
      pulses = 0;
      step(11, 0, 2, 1, 0, 0);
      for (int g = 0; g < 3; g++) begin
         for (int j = 0; j < 4; j++) begin
            step(3, 1, 0, 1, a1[j], a2[j]);
            if (o_valid === 1'b1) pulses++;
            n_tests++;
            if (o_valid !== (j == 3)) begin
               n_fail++;
               $display("FAIL fixed_valid g%0d j%0d: got %b want %b", g, j, o_valid, (j == 3));
            end
            if (j == 3) begin
               n_tests++;
               if (o_data_ch1 !== 14'(e1) || o_data_ch2 !== 14'(e2)) begin
                  n_fail++;
                  $display("FAIL fixed_data g%0d: got %0d/%0d want %0d/%0d", g,
                           $signed(o_data_ch1), $signed(o_data_ch2), e1, e2);
               end
            end
            n_tests++;
            if (dut_v !== exp_v()) begin
               n_fail++;
               $display("FAIL fixed_model g%0d j%0d: got %h want %h", g, j, dut_v, exp_v());
            end
         end
      end
      step(1, 1, 0, 1, 0, 0);
      n_tests++;
      if (pulses != 3) begin
         n_fail++;
         $display("FAIL fixed_pulses: got %0d want 3", pulses);
      end
   endtask

   task automatic test_overrun();
      int a1[6];
      int a2[6];
      int e1;
      for (int i = 0; i < 6; i++) begin a1[i] = rnd_sample(); a2[i] = rnd_sample(); end
`ifdef ADC_DECIMATOR_AVERAGE_EN
      e1 = floor_div(longint'(a1[0]) + a1[1], 2);
`else
      e1 = a1[0];
`endif
      step(11, 0, 1, 1, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(3, 1, 0, 0, a1[i], a2[i]);
         if (i == 1 || i == 3 || i == 5) begin
            n_tests++;
            if (o_valid !== 1'b1 || o_overrun !== (i != 1) || o_data_ch1 !== 14'(e1)) begin
               n_fail++;
               $display("FAIL overrun_hold %0d: got v=%b o=%b d=%0d want v=1 o=%b d=%0d", i,
                        o_valid, o_overrun, $signed(o_data_ch1), (i != 1), e1);
            end
         end
         n_tests++;
         if (dut_v !== exp_v()) begin
            n_fail++;
            $display("FAIL overrun_model %0d: got %h want %h", i, dut_v, exp_v());
         end
      end
      step(0, 1, 0, 0, 0, 0);
      n_tests++;
      if (o_overrun !== 1'b0 || o_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL overrun_clear: got o=%b v=%b want 0 0", o_overrun, o_valid);
      end
   endtask

   task automatic test_partial();
      int f1[8];
      int f2[8];
      int e1;
      longint s;
      s = 0;
      for (int i = 0; i < 8; i++) begin f1[i] = rnd_sample(); f2[i] = rnd_sample(); s += f1[i]; end
`ifdef ADC_DECIMATOR_AVERAGE_EN
      e1 = floor_div(s, 8);
`else
      e1 = f1[0];
`endif
      step(11, 0, 3, 1, 0, 0);
      for (int i = 0; i < 7; i++) begin
         if (i < 5) step(3, 1, 0, 1, rnd_sample(), rnd_sample());
         else       step(4, 1, 0, 1, 0, 0);
         n_tests++;
         if (o_valid !== 1'b0 || o_busy !== (i < 5)) begin
            n_fail++;
            $display("FAIL partial_none %0d: got v=%b b=%b want v=0 b=%b", i, o_valid, o_busy, (i < 5));
         end
      end
      for (int i = 0; i < 8; i++) begin
         step(3, 1, 0, 1, f1[i], f2[i]);
         n_tests++;
         if (o_valid !== (i == 7) || (i == 7 && o_data_ch1 !== 14'(e1))) begin
            n_fail++;
            $display("FAIL partial_fresh %0d: got v=%b d=%0d want v=%b d=%0d", i, o_valid,
                     $signed(o_data_ch1), (i == 7), e1);
         end
         n_tests++;
         if (dut_v !== exp_v()) begin
            n_fail++;
            $display("FAIL partial_model %0d: got %h want %h", i, dut_v, exp_v());
         end
      end
      step(1, 1, 0, 1, 0, 0);
   endtask

   task automatic test_clamp_async();
      int pulses;
      int d;
      pulses = 0;
      step(11, 0, 12, 1, 0, 0);
      for (int i = 0; i < 256; i++) begin
         step(3, 1, 0, 1, rnd_sample(), rnd_sample());
         if (o_valid === 1'b1) pulses++;
         if (dut_v !== exp_v()) begin
            n_fail++;
            $display("FAIL clamp_model %0d: got %h want %h", i, dut_v, exp_v());
         end
      end
      n_tests++;
      if (pulses != 1 || o_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL clamp_k8: got pulses=%0d v=%b want 1 1", pulses, o_valid);
      end
      for (int i = 0; i < 37; i++) step(3, 1, 0, 1, rnd_sample(), rnd_sample());
      #1;
      i_reset_n = 1'b0;
      #1;
      n_tests++;
      if (dut_v !== 31'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %h want %h", dut_v, 31'd0);
      end
      model_reset();
      #1;
      i_reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = rnd_sample();
         step(3, 1, 0, 1, d, 0);
         n_tests++;
         if (o_valid !== 1'b1 || o_data_ch1 !== 14'(d)) begin
            n_fail++;
            $display("FAIL reset_k0 %0d: got v=%b d=%0d want v=1 d=%0d", i, o_valid, $signed(o_data_ch1), d);
         end
      end
      step(1, 1, 0, 1, 0, 0);
   endtask

   task automatic test_random();
      int st, len, dec, r;
      bit init, rdy;
      for (int b = 0; b < 60; b++) begin
         r = int'($urandom_range(0, 9));
         if (r < 6)       st = 3;
         else if (r == 6) st = 0;
         else if (r == 7) st = 11;
         else             st = int'($urandom_range(1, 12));
         len = int'($urandom_range(1, 20));
         for (int c = 0; c < len; c++) begin
            init = ($urandom_range(0, 15) != 0);
            rdy  = ($urandom_range(0, 3) != 0);
            dec  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 3));
            step(st, init, dec, rdy, rnd_sample(), rnd_sample());
            n_tests++;
            if (dut_v !== exp_v()) begin
               n_fail++;
               $display("FAIL random b%0d c%0d: got %h want %h", b, c, dut_v, exp_v());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_ramp_k0();
      test_fixed_k2();
      test_overrun();
      test_partial();
      test_clamp_async();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
